// File: rtl/decoder_scan_sequencer.sv
// Scan driver for a 3-to-8 active-low decoder: steps sel through NUM_LINES lines with a
// programmable dwell and optional blanking gap. Define SCAN_SEQ_REVERSE_EN to add a dir input.
module decoder_scan_sequencer #(
    parameter int DWELL_W   = 16,
    parameter int NUM_LINES = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic               one_shot,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [DWELL_W-1:0] blank,
`ifdef SCAN_SEQ_REVERSE_EN
    input  logic               dir,
`endif
    output logic [2:0]         sel,
    output logic [2:0]         en,
    output logic               busy,
    output logic               line_done,
    output logic               frame_done
);

    localparam logic [2:0]         LAST_LINE = 3'(NUM_LINES - 1);
    localparam logic [2:0]         EN_ON     = 3'b001;
    localparam logic [2:0]         EN_OFF    = 3'b110;
    localparam logic [DWELL_W-1:0] ONE       = {{(DWELL_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, ACTIVE, BLANK} state_e;

    state_e             state_q, state_d;
    logic [2:0]         sel_q, sel_d;
    logic [2:0]         en_q, en_d;
    logic               busy_q, busy_d;
    logic               line_done_q, line_done_d;
    logic               frame_done_q, frame_done_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [DWELL_W-1:0] blank_q, blank_d;
    logic               one_shot_q, one_shot_d;
    logic               down_q, down_d;

    logic               dir_start;
    logic [DWELL_W-1:0] dwell_eff;
    logic [2:0]         nxt_line;
    logic               go_idle;

`ifdef SCAN_SEQ_REVERSE_EN
    assign dir_start = dir;
`else
    assign dir_start = 1'b0;
`endif

    assign dwell_eff = (dwell == '0) ? ONE : dwell;

    function automatic logic is_end_line(input logic [2:0] line, input logic down);
        return down ? (line == 3'd0) : (line == LAST_LINE);
    endfunction

    function automatic logic [2:0] next_line(input logic [2:0] line, input logic down);
        if (down) return (line == 3'd0) ? LAST_LINE : line - 3'd1;
        return (line == LAST_LINE) ? 3'd0 : line + 3'd1;
    endfunction

    // cnt_q holds the cycles remaining in the current line or gap, minus one, so the
    // line_done pulse can be registered one edge ahead of the final enabled cycle.
    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        en_d         = en_q;
        busy_d       = busy_q;
        cnt_d        = cnt_q;
        line_done_d  = 1'b0;
        frame_done_d = 1'b0;
        dwell_d      = dwell_q;
        blank_d      = blank_q;
        one_shot_d   = one_shot_q;
        down_d       = down_q;
        go_idle      = 1'b0;
        nxt_line     = next_line(sel_q, down_q);

        unique case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    dwell_d      = dwell_eff;
                    blank_d      = blank;
                    one_shot_d   = one_shot;
                    down_d       = dir_start;
                    state_d      = ACTIVE;
                    sel_d        = dir_start ? LAST_LINE : 3'd0;
                    en_d         = EN_ON;
                    busy_d       = 1'b1;
                    cnt_d        = dwell_eff - ONE;
                    line_done_d  = (dwell_eff == ONE);
                    frame_done_d = line_done_d && is_end_line(sel_d, dir_start);
                end
            end
            ACTIVE: begin
                if (stop) begin
                    go_idle = 1'b1;
                end else if (cnt_q != '0) begin
                    cnt_d        = cnt_q - ONE;
                    line_done_d  = (cnt_q == ONE);
                    frame_done_d = line_done_d && is_end_line(sel_q, down_q);
                end else if (is_end_line(sel_q, down_q) && one_shot_q) begin
                    go_idle = 1'b1;
                end else if (blank_q == '0) begin
                    sel_d        = nxt_line;
                    cnt_d        = dwell_q - ONE;
                    line_done_d  = (dwell_q == ONE);
                    frame_done_d = line_done_d && is_end_line(nxt_line, down_q);
                end else begin
                    state_d = BLANK;
                    en_d    = EN_OFF;
                    cnt_d   = blank_q - ONE;
                end
            end
            BLANK: begin
                if (stop) begin
                    go_idle = 1'b1;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - ONE;
                end else begin
                    state_d      = ACTIVE;
                    sel_d        = nxt_line;
                    en_d         = EN_ON;
                    cnt_d        = dwell_q - ONE;
                    line_done_d  = (dwell_q == ONE);
                    frame_done_d = line_done_d && is_end_line(nxt_line, down_q);
                end
            end
            default: go_idle = 1'b1;
        endcase

        if (go_idle) begin
            state_d      = IDLE;
            sel_d        = 3'd0;
            en_d         = EN_OFF;
            busy_d       = 1'b0;
            cnt_d        = '0;
            line_done_d  = 1'b0;
            frame_done_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            sel_q        <= 3'd0;
            en_q         <= EN_OFF;
            busy_q       <= 1'b0;
            line_done_q  <= 1'b0;
            frame_done_q <= 1'b0;
            cnt_q        <= '0;
            dwell_q      <= '0;
            blank_q      <= '0;
            one_shot_q   <= 1'b0;
            down_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            en_q         <= en_d;
            busy_q       <= busy_d;
            line_done_q  <= line_done_d;
            frame_done_q <= frame_done_d;
            cnt_q        <= cnt_d;
            dwell_q      <= dwell_d;
            blank_q      <= blank_d;
            one_shot_q   <= one_shot_d;
            down_q       <= down_d;
        end
    end

    assign sel        = sel_q;
    assign en         = en_q;
    assign busy       = busy_q;
    assign line_done  = line_done_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_decoder_scan_sequencer.sv
// Bench for decoder_scan_sequencer: builds the expected per-cycle output trace of each scan
// from nested line/dwell/blank loops and compares it with the DUT on every falling edge.
module tb_decoder_scan_sequencer;

    localparam int DW = 16;
    localparam int NL = 8;

    typedef struct packed {
        logic [2:0] sel;
        logic [2:0] en;
        logic       busy;
        logic       ld;
        logic       fd;
    } outs_t;

    localparam logic [2:0] EN_ON     = 3'b001;
    localparam logic [2:0] EN_OFF    = 3'b110;
    localparam outs_t      IDLE_OUTS = 9'b000_110_000;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          stop;
    logic          oneShotIn;
    logic [DW-1:0] dwellIn;
    logic [DW-1:0] blankIn;
    logic          dirIn;
    logic [2:0]    sel;
    logic [2:0]    en;
    logic          busy;
    logic          lineDone;
    logic          frameDone;
    outs_t         dutOuts;

    outs_t expQ[$];
    int    errors   = 0;
    int    checks   = 0;
    bit    checking = 0;

    decoder_scan_sequencer #(.DWELL_W(DW), .NUM_LINES(NL)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .stop      (stop),
        .one_shot  (oneShotIn),
        .dwell     (dwellIn),
        .blank     (blankIn),
`ifdef SCAN_SEQ_REVERSE_EN
        .dir       (dirIn),
`endif
        .sel       (sel),
        .en        (en),
        .busy      (busy),
        .line_done (lineDone),
        .frame_done(frameDone)
    );

    assign dutOuts = {sel, en, busy, lineDone, frameDone};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic outs_t mk(logic [2:0] s, logic [2:0] e, logic b, logic l, logic f);
        return {s, e, b, l, f};
    endfunction

    task automatic checkOutput(string name, outs_t actual, outs_t expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s @%0t: got sel=%0d en=%b busy=%b ld=%b fd=%b, expected sel=%0d en=%b busy=%b ld=%b fd=%b",
                     name, $time, actual.sel, actual.en, actual.busy, actual.ld, actual.fd,
                     expected.sel, expected.en, expected.busy, expected.ld, expected.fd);
        end
    endtask

    // Expected trace, one entry per cycle starting with the cycle start is raised:
    // frames of lines, each line dwell enabled cycles then blank disabled cycles,
    // cut short after stopAt active cycles (0 = never) or at the end of a one-shot frame.
    function automatic void buildTrace(int dw, int bl, bit oneShot, bit dirDown, int stopAt);
        int  d     = (dw == 0) ? 1 : dw;
        int  count = 0;
        bit  done  = 0;
        expQ.push_back(IDLE_OUTS);
        while (!done) begin
            for (int i = 0; i < NL && !done; i++) begin
                int line     = dirDown ? NL - 1 - i : i;
                bit lastLine = (i == NL - 1);
                for (int k = 0; k < d && !done; k++) begin
                    expQ.push_back(mk(3'(line), EN_ON, 1'b1, k == d - 1, (k == d - 1) && lastLine));
                    count++;
                    if ((stopAt > 0 && count == stopAt) || count > 5000) done = 1;
                end
                if (!done && lastLine && oneShot) done = 1;
                for (int k = 0; k < bl && !done; k++) begin
                    expQ.push_back(mk(3'(line), EN_OFF, 1'b1, 1'b0, 1'b0));
                    count++;
                    if ((stopAt > 0 && count == stopAt) || count > 5000) done = 1;
                end
            end
        end
        expQ.push_back(IDLE_OUTS);
    endfunction

    // Every falling edge out of reset: DUT against the next trace entry, or idle if none.
    initial begin
        outs_t e;
        forever begin
            @(negedge clk);
            if (rst_n && checking) begin
                e = (expQ.size() > 0) ? expQ.pop_front() : IDLE_OUTS;
                checkOutput("trace", dutOuts, e);
            end
        end
    end

    // One scan: start in cycle 0, stop held during cycle stopAt, a stray start during
    // cycle startAgainAt, and scrambled config inputs once the scan is underway.
    task automatic applyStimulus(int dw, int bl, bit oneShot, bit dirDown, int stopAt, int startAgainAt);
        int c = 0;
        @(posedge clk);
        #1;
        buildTrace(dw, bl, oneShot, dirDown, stopAt);
        dwellIn   = DW'(dw);
        blankIn   = DW'(bl);
        oneShotIn = oneShot;
        dirIn     = dirDown;
        start     = 1'b1;
        while (expQ.size() > 0 && c < 3000) begin
            @(posedge clk);
            #1;
            c++;
            start = (c == startAgainAt);
            stop  = (c == stopAt);
            if (c == 1) begin
                dwellIn   = 16'd7;
                blankIn   = 16'd0;
                oneShotIn = !oneShot;
                dirIn     = !dirDown;
            end
        end
        start = 1'b0;
        stop  = 1'b0;
        if (expQ.size() > 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scan_timeout: %0d trace entries left, required 0", expQ.size());
            expQ.delete();
        end
    endtask

    task automatic checkCycle(int c, string name, outs_t expected);
        @(posedge clk);
        repeat (c) @(posedge clk);
        @(negedge clk);
        checkOutput(name, dutOuts, expected);
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        stop      = 1'b0;
        oneShotIn = 1'b0;
        dwellIn   = '0;
        blankIn   = '0;
        dirIn     = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        checkOutput("reset_state", dutOuts, IDLE_OUTS);
        @(negedge clk);
        rst_n    = 1'b1;
        checking = 1'b1;
        repeat (2) @(posedge clk);

        $display("[TB] one-shot dwell=2 blank=0");
        fork
            applyStimulus(2, 0, 1'b1, 1'b0, 0, 0);
            checkCycle(1, "oneshot_first", mk(3'd0, EN_ON, 1'b1, 1'b0, 1'b0));
            checkCycle(2, "oneshot_line0_done", mk(3'd0, EN_ON, 1'b1, 1'b1, 1'b0));
            checkCycle(16, "oneshot_frame_done", mk(3'd7, EN_ON, 1'b1, 1'b1, 1'b1));
            checkCycle(17, "oneshot_idle", IDLE_OUTS);
        join

        $display("[TB] continuous dwell=1 blank=2, stray start, stop after two frames");
        fork
            applyStimulus(1, 2, 1'b0, 1'b0, 53, 10);
            checkCycle(11, "start_while_busy", mk(3'd3, EN_OFF, 1'b1, 1'b0, 1'b0));
            checkCycle(22, "cont_frame_done", mk(3'd7, EN_ON, 1'b1, 1'b1, 1'b1));
            checkCycle(23, "cont_blank", mk(3'd7, EN_OFF, 1'b1, 1'b0, 1'b0));
            checkCycle(25, "cont_wrap", mk(3'd0, EN_ON, 1'b1, 1'b1, 1'b0));
            checkCycle(46, "cont_frame2_done", mk(3'd7, EN_ON, 1'b1, 1'b1, 1'b1));
        join

        $display("[TB] one-shot dwell=0 blank=1");
        fork
            applyStimulus(0, 1, 1'b1, 1'b0, 0, 0);
            checkCycle(15, "dwell0_frame_done", mk(3'd7, EN_ON, 1'b1, 1'b1, 1'b1));
            checkCycle(16, "dwell0_final_blank_skipped", IDLE_OUTS);
        join

        $display("[TB] stop on last cycle of line 3");
        fork
            applyStimulus(3, 1, 1'b0, 1'b0, 15, 0);
            checkCycle(14, "line3_mid", mk(3'd3, EN_ON, 1'b1, 1'b0, 1'b0));
            checkCycle(16, "stop_idle", IDLE_OUTS);
        join

        $display("[TB] one-shot dwell=5 blank=3");
        applyStimulus(5, 3, 1'b1, 1'b0, 0, 0);

`ifdef SCAN_SEQ_REVERSE_EN
        $display("[TB] reverse one-shot dwell=1");
        fork
            applyStimulus(1, 0, 1'b1, 1'b1, 0, 0);
            checkCycle(1, "rev_first", mk(3'd7, EN_ON, 1'b1, 1'b1, 1'b0));
            checkCycle(8, "rev_frame_done", mk(3'd0, EN_ON, 1'b1, 1'b1, 1'b1));
            checkCycle(9, "rev_idle", IDLE_OUTS);
        join
`endif

        $display("[TB] start with stop in idle, stop alone in idle");
        @(posedge clk);
        #1;
        dwellIn = 16'd1;
        start   = 1'b1;
        stop    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        stop = 1'b0;
        @(negedge clk);
        checkOutput("idle_start_stop", dutOuts, IDLE_OUTS);

        $display("[TB] asynchronous reset mid-scan");
        @(posedge clk);
        #1;
        buildTrace(2, 1, 1'b0, 1'b0, 100);
        dwellIn   = 16'd2;
        blankIn   = 16'd1;
        oneShotIn = 1'b0;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset", dutOuts, IDLE_OUTS);
        expQ.delete();
        @(negedge clk);
        checkOutput("held_in_reset", dutOuts, IDLE_OUTS);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
